if_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and issues word fetches to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions in a small FIFO so decode can stall without losing in-flight fetches.
- Presents {instruction, pc} to decode with a valid/ready handshake; accepts redirects (branch/jump/trap) from execute.

---
 rtl/if_stage.sv | 151 +++++++++++++++
 tb/tb_if_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Fetch stage: owns the PC, issues word fetches to a 1-cycle imem and buffers {instr, pc} for decode.
// Latency: fetch issued cycle N, visible to decode at N+2. Optional misalignment trap: IF_MISALIGN_CHECK_EN.
// Backpressure: issue stops once buffered + in-flight entries would exceed FETCH_BUF_DEPTH after this cycle's pop.
module if_stage #(
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0,
  parameter int                    FETCH_BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  id_ready_i,
  output logic                  id_valid_o,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  misaligned_o
);

  localparam int CW = $clog2(FETCH_BUF_DEPTH + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
  } entry_t;

  logic [DATA_WIDTH-1:0] pc_q, inflight_pc_q, target_pc;
  logic                  inflight_q, push_vld, pop, fetch_block;
  logic [CW-1:0]         fifo_cnt;
  logic [CW:0]           occ;
  entry_t                push_dat, head_dat;

`ifdef IF_MISALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge clk) begin
    if (rst)             mis_q <= 1'b0;
    else if (redirect_i) mis_q <= |redirect_pc_i[1:0];
  end

  assign misaligned_o = mis_q;
  assign fetch_block  = mis_q;
  assign target_pc    = redirect_pc_i;
`else
  assign misaligned_o = 1'b0;
  assign fetch_block  = 1'b0;
  assign target_pc    = redirect_pc_i & ~DATA_WIDTH'(3);
`endif

  // A pop this cycle frees a slot before the response to this cycle's request lands.
  assign pop  = id_valid_o && id_ready_i;
  assign occ  = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};

  assign imem_req_o  = !rst && !redirect_i && !fetch_block && (occ < (CW+1)'(FETCH_BUF_DEPTH));
  assign imem_addr_o = pc_q;

  assign push_vld = inflight_q && !redirect_i;
  assign push_dat = '{instr: imem_rdata_i, pc: inflight_pc_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_i) begin
      pc_q       <= target_pc;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= imem_req_o;
      if (imem_req_o) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + DATA_WIDTH'(4);
      end
    end
  end

  fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FETCH_BUF_DEPTH)
  ) u_fetch_buf (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirect_i),
    .wr_vld (push_vld),
    .wr_dat (push_dat),
    .rd_rdy (id_ready_i),
    .rd_vld (id_valid_o),
    .rd_dat (head_dat),
    .cnt    (fifo_cnt)
  );

  assign instruction_o = head_dat.instr;
  assign pc_o          = head_dat.pc;

endmodule

// Generic synchronous FIFO with flush; head data reads as zero when empty.
// Latency: write visible at the head the cycle after the push.
// Backpressure: a push into a full FIFO is accepted only alongside a pop; otherwise dropped.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_vld,
  input  logic [WIDTH-1:0]           wr_dat,
  input  logic                       rd_rdy,
  output logic                       rd_vld,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign rd_vld = (cnt != '0);
  assign rd_en  = rd_vld && rd_rdy;
  assign wr_en  = wr_vld && ((cnt < CW'(DEPTH)) || rd_en);
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en && !rst && !flush) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, decode stall, redirects, mid-run reset and misaligned targets.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, redirect, id_ready;
  logic [31:0] redirect_pc, imem_addr, instruction, pc;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, id_valid, misaligned;
  int          checks = 0;
  int          failures = 0;

  if_stage #(
    .DATA_WIDTH      (32),
    .RESET_PC        (32'h0000_0000),
    .FETCH_BUF_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .id_ready_i    (id_ready),
    .id_valid_o    (id_valid),
    .instruction_o (instruction),
    .pc_o          (pc),
    .misaligned_o  (misaligned)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle read, word = address tagged with 0x13 in the top byte.
  always @(posedge clk) imem_rdata <= imem_req ? (imem_addr | 32'h1300_0000) : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Leaves the bench just after the edge that starts the first cycle out of reset.
  task automatic do_reset(input logic rdy);
    step();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = rdy;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    step(); step();
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", id_valid); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", imem_req); end
    checks++; if (instruction !== 32'h0 || pc !== 32'h0) begin failures++; $display("FAIL reset_outs instr=%h pc=%h want=0/0", instruction, pc); end
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%b want=0", misaligned); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        failures++; $display("FAIL stream_req k=%0d req=%b addr=%h want 1/%h", k, imem_req, imem_addr, 32'(4 * k));
      end
      checks++;
      if (k < 2) begin
        if (id_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid k=%0d got=%b want=0", k, id_valid); end
      end else begin
        exp_pc = 32'(4 * (k - 2));
        if (id_valid !== 1'b1 || pc !== exp_pc || instruction !== (exp_pc | 32'h1300_0000)) begin
          failures++; $display("FAIL stream_out k=%0d v=%b pc=%h instr=%h want 1/%h/%h", k, id_valid, pc, instruction, exp_pc, exp_pc | 32'h1300_0000);
        end
      end
    end
  endtask

  task automatic test_stall();
    int          exp_req [11];
    int          exp_v   [11];
    logic [31:0] exp_addr[11];
    logic [31:0] exp_pc  [11];
    exp_req  = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    exp_addr = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8, 32'hC, 32'h10, 32'h14};
    exp_v    = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    exp_pc   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
    do_reset(1'b0);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) begin step(); id_ready = (k >= 7); end
      @(negedge clk);
      checks++;
      if (imem_req !== 1'(exp_req[k]) || (exp_req[k] == 1 && imem_addr !== exp_addr[k])) begin
        failures++; $display("FAIL stall_req k=%0d req=%b addr=%h want %0d/%h", k, imem_req, imem_addr, exp_req[k], exp_addr[k]);
      end
      checks++;
      if (id_valid !== 1'(exp_v[k]) || (exp_v[k] == 1 && pc !== exp_pc[k])) begin
        failures++; $display("FAIL stall_out k=%0d v=%b pc=%h want %0d/%h", k, id_valid, pc, exp_v[k], exp_pc[k]);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_req_in_cycle got=%b want=0", imem_req); end
    step(); redirect = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%b pc=%h want valid=0", id_valid, pc); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL redir_first_fetch req=%b addr=%h want 1/100", imem_req, imem_addr); end
    step(); @(negedge clk);
    checks++; if (id_valid !== 1'b0 || imem_addr !== 32'h104) begin failures++; $display("FAIL redir_gap v=%b addr=%h want 0/104", id_valid, imem_addr); end
    for (int k = 0; k < 3; k++) begin
      step(); @(negedge clk);
      checks++;
      if (id_valid !== 1'b1 || pc !== 32'(32'h100 + 4 * k) || instruction !== 32'(32'h1300_0100 + 4 * k)) begin
        failures++; $display("FAIL redir_out k=%0d v=%b pc=%h instr=%h want 1/%h", k, id_valid, pc, instruction, 32'(32'h100 + 4 * k));
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    step(); step(); step();
    redirect = 1'b1; redirect_pc = 32'h200;
    step(); redirect_pc = 32'h300;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin failures++; $display("FAIL b2b_second req=%b v=%b want 0/0", imem_req, id_valid); end
    step(); redirect = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL b2b_fetch req=%b addr=%h want 1/300", imem_req, imem_addr); end
    step(); @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL b2b_stale v=%b pc=%h want 0", id_valid, pc); end
    for (int k = 0; k < 2; k++) begin
      step(); @(negedge clk);
      checks++;
      if (id_valid !== 1'b1 || pc !== 32'(32'h300 + 4 * k)) begin
        failures++; $display("FAIL b2b_out k=%0d v=%b pc=%h want 1/%h", k, id_valid, pc, 32'(32'h300 + 4 * k));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    step(); step(); step();
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || pc !== 32'h0) begin failures++; $display("FAIL rmid_pre v=%b pc=%h want 1/0", id_valid, pc); end
    step(); rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h500;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rmid_req_in_reset got=%b want=0", imem_req); end
    step(); rst = 1'b0; redirect = 1'b0;
    @(negedge clk);
    checks++; if (id_valid !== 1'b0 || pc !== 32'h0 || instruction !== 32'h0) begin failures++; $display("FAIL rmid_flush v=%b pc=%h instr=%h want 0/0/0", id_valid, pc, instruction); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rmid_pc req=%b addr=%h want 1/0", imem_req, imem_addr); end
    step(); @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rmid_stale_push v=%b pc=%h want 0", id_valid, pc); end
    step(); @(negedge clk);
    checks++; if (id_valid !== 1'b1 || pc !== 32'h0 || instruction !== 32'h1300_0000) begin failures++; $display("FAIL rmid_restart v=%b pc=%h instr=%h want 1/0/13000000", id_valid, pc, instruction); end
  endtask

  task automatic test_misalign();
    do_reset(1'b1);
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h102;
    step(); redirect = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (misaligned !== 1'b1 || imem_req !== 1'b0 || id_valid !== 1'b0) begin
        failures++; $display("FAIL mis_hold k=%0d mis=%b req=%b v=%b want 1/0/0", k, misaligned, imem_req, id_valid);
      end
      step();
    end
    redirect = 1'b1; redirect_pc = 32'h104;
    step(); redirect = 1'b0;
    @(negedge clk);
    checks++; if (misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h104) begin failures++; $display("FAIL mis_clear mis=%b req=%b addr=%h want 0/1/104", misaligned, imem_req, imem_addr); end
    step(); step(); @(negedge clk);
    checks++; if (id_valid !== 1'b1 || pc !== 32'h104 || instruction !== 32'h1300_0104) begin failures++; $display("FAIL mis_resume v=%b pc=%h instr=%h want 1/104/13000104", id_valid, pc, instruction); end
`else
    @(negedge clk);
    checks++; if (misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL mis_align mis=%b req=%b addr=%h want 0/1/100", misaligned, imem_req, imem_addr); end
    step(); step(); @(negedge clk);
    checks++; if (id_valid !== 1'b1 || pc !== 32'h100 || instruction !== 32'h1300_0100) begin failures++; $display("FAIL mis_out v=%b pc=%h instr=%h want 1/100/13000100", id_valid, pc, instruction); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
